// File: rtl/step_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : step_counter_bank
// Brief    : NUM_CH independent up/down step counters with clear, load,
//            modulo wrap or saturation, and registered terminal-count pulses.
// Revision : 1.0 - initial release
// ============================================================================
module step_counter_bank #(
    parameter int NUM_CH        = 4,
    parameter int COUNTER_WIDTH = 3,
    parameter int ADD_VAL       = 1,
    parameter int MOD_VAL       = 2**COUNTER_WIDTH,
    parameter int WRAP_MODE     = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CH-1:0]               cnt,
    input  logic [NUM_CH-1:0]               dir,
    input  logic [NUM_CH-1:0]               clear,
    input  logic [NUM_CH-1:0]               load,
    input  logic [NUM_CH*COUNTER_WIDTH-1:0] load_val,
    output logic [NUM_CH*COUNTER_WIDTH-1:0] count,
    output logic [NUM_CH-1:0]               tc,
    output logic                            any_tc
);

    localparam int                   c_W   = COUNTER_WIDTH;
    localparam int                   c_W1  = COUNTER_WIDTH + 1;
    localparam logic [c_W:0]         c_MOD = c_W1'(MOD_VAL);
    localparam logic [c_W:0]         c_ADD = c_W1'(ADD_VAL);
    localparam logic [c_W-1:0]       c_MAX = c_W'(MOD_VAL - 1);

    generate
        if (NUM_CH < 1 || COUNTER_WIDTH < 1 || ADD_VAL < 1 || ADD_VAL >= MOD_VAL ||
            MOD_VAL < 2 || MOD_VAL > 2**COUNTER_WIDTH) begin : g_param_check
            $fatal(1, "step_counter_bank: illegal parameter combination");
        end
    endgenerate

    logic [NUM_CH*c_W-1:0] r_count;
    logic [NUM_CH-1:0]     r_tc;
    logic                  r_any_tc;
    logic [NUM_CH*c_W-1:0] w_count_nxt;
    logic [NUM_CH-1:0]     w_tc_nxt;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [c_W:0]   w_cur;
            logic [c_W:0]   w_sum;
            logic [c_W:0]   w_ld;
            logic [c_W-1:0] w_wrap_up;
            logic [c_W-1:0] w_dec;
            logic [c_W-1:0] w_wrap_dn;
            logic [c_W-1:0] w_nxt;
            logic           w_tcn;

            // One extra bit so sums and boundary compares never alias.
            assign w_cur     = {1'b0, r_count[i*c_W +: c_W]};
            assign w_sum     = w_cur + c_ADD;
            assign w_ld      = {1'b0, load_val[i*c_W +: c_W]};
            assign w_wrap_up = c_W'(w_sum - c_MOD);
            assign w_dec     = c_W'(w_cur - c_ADD);
            assign w_wrap_dn = c_W'(w_cur + c_MOD - c_ADD);

            always_comb begin
                w_nxt = r_count[i*c_W +: c_W];
                w_tcn = 1'b0;
                if (clear[i]) begin
                    w_nxt = '0;
                end else if (load[i]) begin
                    w_nxt = (w_ld < c_MOD) ? w_ld[c_W-1:0] : c_MAX;
                end else if (cnt[i]) begin
                    if (!dir[i]) begin
                        if (w_sum < c_MOD) begin
                            w_nxt = w_sum[c_W-1:0];
                        end else begin
                            w_tcn = 1'b1;
                            w_nxt = (WRAP_MODE != 0) ? w_wrap_up : c_MAX;
                        end
                    end else begin
                        if (w_cur >= c_ADD) begin
                            w_nxt = w_dec;
                        end else begin
                            w_tcn = 1'b1;
                            w_nxt = (WRAP_MODE != 0) ? w_wrap_dn : '0;
                        end
                    end
                end
            end

            assign w_count_nxt[i*c_W +: c_W] = w_nxt;
            assign w_tc_nxt[i]               = w_tcn;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count  <= '0;
            r_tc     <= '0;
            r_any_tc <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_tc     <= w_tc_nxt;
            r_any_tc <= |w_tc_nxt;
        end
    end

    assign count  = r_count;
    assign tc     = r_tc;
    assign any_tc = r_any_tc;

endmodule
`default_nettype wire

// File: tb/tb_step_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_counter_bank
// Brief    : Directed, table-driven bench for step_counter_bank (wrap,
//            saturate and default free-running configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_step_counter_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cnt, dir, clear, load;
    logic [15:0] load_val;
    logic [11:0] load_val_d;
    logic [15:0] count_w, count_s;
    logic [11:0] count_d;
    logic [3:0]  tc_w, tc_s, tc_d;
    logic        any_w, any_s, any_d;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    step_counter_bank #(.NUM_CH(4), .COUNTER_WIDTH(4), .ADD_VAL(3), .MOD_VAL(10), .WRAP_MODE(1)) u_wrap (
        .clk(clk), .reset(reset), .cnt(cnt), .dir(dir), .clear(clear), .load(load),
        .load_val(load_val), .count(count_w), .tc(tc_w), .any_tc(any_w));

    step_counter_bank #(.NUM_CH(4), .COUNTER_WIDTH(4), .ADD_VAL(3), .MOD_VAL(10), .WRAP_MODE(0)) u_sat (
        .clk(clk), .reset(reset), .cnt(cnt), .dir(dir), .clear(clear), .load(load),
        .load_val(load_val), .count(count_s), .tc(tc_s), .any_tc(any_s));

    step_counter_bank u_def (
        .clk(clk), .reset(reset), .cnt(cnt), .dir(dir), .clear(clear), .load(load),
        .load_val(load_val_d), .count(count_d), .tc(tc_d), .any_tc(any_d));

    typedef struct packed {
        logic [3:0]  cnt, dir, clr, ld;
        logic [15:0] lv;
        logic [15:0] wcnt;
        logic [3:0]  wtc;
        logic [15:0] scnt;
        logic [3:0]  stc;
    } vec_t;

    vec_t tbl [24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        //          cnt   dir   clr   ld    lv        wcnt      wtc   scnt      stc
        tbl[0]  = '{4'h0, 4'h0, 4'hF, 4'h0, 16'h0000, 16'h0000, 4'h0, 16'h0000, 4'h0};
        tbl[1]  = '{4'h1, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0003, 4'h0, 16'h0003, 4'h0};
        tbl[2]  = '{4'h1, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0006, 4'h0, 16'h0006, 4'h0};
        tbl[3]  = '{4'h1, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0009, 4'h0, 16'h0009, 4'h0};
        tbl[4]  = '{4'h1, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0002, 4'h1, 16'h0009, 4'h1};
        tbl[5]  = '{4'h1, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0005, 4'h0, 16'h0009, 4'h1};
        tbl[6]  = '{4'h0, 4'h0, 4'h0, 4'h1, 16'h0001, 16'h0001, 4'h0, 16'h0001, 4'h0};
        tbl[7]  = '{4'h1, 4'h1, 4'h0, 4'h0, 16'h0000, 16'h0008, 4'h1, 16'h0000, 4'h1};
        tbl[8]  = '{4'h1, 4'h1, 4'h0, 4'h0, 16'h0000, 16'h0005, 4'h0, 16'h0000, 4'h1};
        tbl[9]  = '{4'h1, 4'h1, 4'h0, 4'h0, 16'h0000, 16'h0002, 4'h0, 16'h0000, 4'h1};
        tbl[10] = '{4'h1, 4'h1, 4'h0, 4'h0, 16'h0000, 16'h0009, 4'h1, 16'h0000, 4'h1};
        tbl[11] = '{4'h0, 4'h0, 4'h0, 4'h1, 16'h0007, 16'h0007, 4'h0, 16'h0007, 4'h0};
        tbl[12] = '{4'h1, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0000, 4'h1, 16'h0009, 4'h1};
        tbl[13] = '{4'h1, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0003, 4'h0, 16'h0009, 4'h1};
        tbl[14] = '{4'h0, 4'h0, 4'h0, 4'h1, 16'h0002, 16'h0002, 4'h0, 16'h0002, 4'h0};
        tbl[15] = '{4'h1, 4'h1, 4'h0, 4'h0, 16'h0000, 16'h0009, 4'h1, 16'h0000, 4'h1};
        tbl[16] = '{4'h1, 4'h0, 4'h1, 4'h1, 16'h0005, 16'h0000, 4'h0, 16'h0000, 4'h0};
        tbl[17] = '{4'h1, 4'h0, 4'h0, 4'hD, 16'hFA0C, 16'h9909, 4'h0, 16'h9909, 4'h0};
        tbl[18] = '{4'h3, 4'h2, 4'h0, 4'h0, 16'h0000, 16'h9972, 4'h3, 16'h9909, 4'h3};
        tbl[19] = '{4'h3, 4'h2, 4'h0, 4'h0, 16'h0000, 16'h9945, 4'h0, 16'h9909, 4'h3};
        tbl[20] = '{4'h4, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h9245, 4'h4, 16'h9909, 4'h4};
        tbl[21] = '{4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h9245, 4'h0, 16'h9909, 4'h0};
        tbl[22] = '{4'h8, 4'h8, 4'h0, 4'h0, 16'h0000, 16'h6245, 4'h0, 16'h6909, 4'h0};
        tbl[23] = '{4'h9, 4'h8, 4'h1, 4'h0, 16'h0000, 16'h3240, 4'h0, 16'h3900, 4'h0};

        // Reset held while stepping is requested.
        reset = 1'b0; cnt = 4'hF; dir = 4'h0; clear = 4'h0; load = 4'h0;
        load_val = 16'h0; load_val_d = 12'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_count_w", 32'(count_w), 32'h0);
        check("rst_tc_w",    32'({tc_w, any_w}), 32'h0);
        check("rst_count_s", 32'(count_s), 32'h0);
        check("rst_count_d", 32'(count_d), 32'h0);
        check("rst_tc_d",    32'({tc_d, any_d}), 32'h0);

        @(negedge clk);
        reset = 1'b1; cnt = 4'h1;
        @(posedge clk); #1;
        check("rel_count_d0", 32'(count_d[2:0]), 32'h1);
        check("rel_count_w",  32'(count_w), 32'h3);
        check("rel_count_s",  32'(count_s), 32'h3);

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            cnt = tbl[i].cnt; dir = tbl[i].dir; clear = tbl[i].clr;
            load = tbl[i].ld; load_val = tbl[i].lv;
            @(posedge clk); #1;
            check($sformatf("v%0d_count_w", i), 32'(count_w), 32'(tbl[i].wcnt));
            check($sformatf("v%0d_tc_w", i),    32'(tc_w),    32'(tbl[i].wtc));
            check($sformatf("v%0d_any_w", i),   32'(any_w),   32'(|tbl[i].wtc));
            check($sformatf("v%0d_count_s", i), 32'(count_s), 32'(tbl[i].scnt));
            check($sformatf("v%0d_tc_s", i),    32'(tc_s),    32'(tbl[i].stc));
            check($sformatf("v%0d_any_s", i),   32'(any_s),   32'(|tbl[i].stc));
        end

        // Default configuration behaves as a plain 3-bit free-running counter.
        @(negedge clk);
        cnt = 4'h0; dir = 4'h0; clear = 4'hF; load = 4'h0; load_val = 16'h0;
        @(posedge clk); #1;
        check("fr_clear_d", 32'(count_d), 32'h0);
        @(negedge clk);
        clear = 4'h0; cnt = 4'h1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            check($sformatf("fr%0d_count_d0", i), 32'(count_d[2:0]), 32'(i % 8));
            check($sformatf("fr%0d_tc_d0", i),    32'(tc_d[0]),      32'(i == 8));
            check($sformatf("fr%0d_any_d", i),    32'(any_d),        32'(i == 8));
        end

        // Asynchronous reset between clock edges.
        @(negedge clk);
        cnt = 4'h0;
        @(posedge clk); #1;
        check("pre_async_count_w0", 32'(count_w[3:0]), 32'h4);
        #1 reset = 1'b0;
        #1;
        check("async_count_w", 32'(count_w), 32'h0);
        check("async_count_s", 32'(count_s), 32'h0);
        check("async_count_d", 32'(count_d), 32'h0);
        check("async_tc_all",  32'({tc_w, tc_s, tc_d, any_w, any_s, any_d}), 32'h0);

        @(negedge clk);
        reset = 1'b1; cnt = 4'h1;
        @(posedge clk); #1;
        check("post_async_count_w", 32'(count_w), 32'h3);
        check("post_async_count_d", 32'(count_d), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
